// File: rtl/mac_seq_pkg.sv
// Shared types and widths for the MAC initiator sequencer.
package mac_seq_pkg;

  localparam int OP_W  = 8;
  localparam int ACC_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    PRESENT
  } state_t;

endpackage

// File: rtl/mac_sequencer.sv
// Initiator for the gated MAC: clears the accumulator, feeds N_TERMS operand
// pairs, waits out the MAC pipeline and hands the accumulated sum downstream.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_vld,
  output logic             op_rdy,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic [OP_W-1:0]  mac_a,
  output logic [OP_W-1:0]  mac_b,
  output logic             mac_en,
  output logic             mac_clr,
  input  logic [ACC_W-1:0] mac_accum,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [ACC_W-1:0] res,
  output logic             busy
);

  localparam int TW = $clog2(N_TERMS + 1);
  localparam int WW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);
  localparam logic [TW-1:0] LAST_TERM = TW'(N_TERMS - 1);
  localparam logic [WW-1:0] LAT_LOAD  = WW'(MAC_LAT);

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] term_cnt;
  logic [WW-1:0] wait_cnt;
  logic          handshake;
  logic          last_term;

  assign op_rdy    = (state == FEED);
  assign busy      = (state != IDLE);
  assign handshake = op_vld & op_rdy;
  assign last_term = handshake && (term_cnt == LAST_TERM);

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode for the clear / feed / drain / present job sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (op_vld) next_state = CLEAR;
      CLEAR:   next_state = FEED;
      FEED:    if (last_term) next_state = DRAIN;
      DRAIN:   if (wait_cnt == '0) next_state = PRESENT;
      PRESENT: if (res_vld && res_rdy) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // MAC drive: clear lands the cycle before the first possible enable, and
  // operands only advance on an accepted pair so mac_en is one pulse per term.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
      mac_a   <= '0;
      mac_b   <= '0;
    end else begin
      mac_clr <= (state == CLEAR);
      mac_en  <= handshake;
      if (handshake) begin
        mac_a <= op_a;
        mac_b <= op_b;
      end
    end
  end

  // Term counter and pipeline-drain countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      term_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        CLEAR: term_cnt <= '0;
        FEED: begin
          if (handshake) begin
            term_cnt <= term_cnt + TW'(1);
          end
          if (last_term) begin
            wait_cnt <= LAT_LOAD;
          end
        end
        DRAIN: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Result capture once the last product has reached the accumulator, held
  // until downstream takes it; res itself keeps its value after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res     <= '0;
      res_vld <= 1'b0;
    end else begin
      if (state == DRAIN && wait_cnt == '0) begin
        res     <= mac_accum;
        res_vld <= 1'b1;
      end else if (state == PRESENT && res_vld && res_rdy) begin
        res_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: a 4-term instance and a 1-term instance,
// each driving a behavioural two-stage MAC model.
`timescale 1ns/1ps
module tb_mac_sequencer;

  localparam int N_TERMS = 4;
  localparam int MAC_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;

  logic        op_vld, op_rdy;
  logic [7:0]  op_a, op_b, mac_a, mac_b;
  logic        mac_en, mac_clr;
  logic [63:0] mac_accum, res;
  logic        res_vld, res_rdy, busy;

  logic        one_op_vld, one_op_rdy;
  logic [7:0]  one_op_a, one_op_b, one_mac_a, one_mac_b;
  logic        one_mac_en, one_mac_clr;
  logic [63:0] one_mac_accum, one_res;
  logic        one_res_vld, one_res_rdy, one_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int   clr_cnt      = 0;
  int   en_cnt       = 0;
  int   last_clr_cyc = 0;
  int   last_hs_cyc  = 0;
  int   rvld_rise    = 0;
  logic prev_res_vld = 1'b0;
  int   en_log[$];
  int   one_en_cnt   = 0;

  mac_sequencer #(.N_TERMS(N_TERMS), .MAC_LAT(MAC_LAT)) u_dut (
    .clk(clk), .rst(rst),
    .op_vld(op_vld), .op_rdy(op_rdy), .op_a(op_a), .op_b(op_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_accum(mac_accum),
    .res_vld(res_vld), .res_rdy(res_rdy), .res(res), .busy(busy)
  );

  mac_sequencer #(.N_TERMS(1), .MAC_LAT(MAC_LAT)) u_dut_one (
    .clk(clk), .rst(rst),
    .op_vld(one_op_vld), .op_rdy(one_op_rdy), .op_a(one_op_a), .op_b(one_op_b),
    .mac_a(one_mac_a), .mac_b(one_mac_b), .mac_en(one_mac_en), .mac_clr(one_mac_clr),
    .mac_accum(one_mac_accum),
    .res_vld(one_res_vld), .res_rdy(one_res_rdy), .res(one_res), .busy(one_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural MAC: product register then accumulate, two cycles enable-to-sum.
  // No reset, so a job abandoned by rst leaves a stale sum behind.
  logic [15:0] prod   = '0;
  logic        prod_v = 1'b0;
  logic [63:0] acc    = '0;
  always @(posedge clk) begin
    if (mac_clr) begin
      prod_v <= 1'b0;
      acc    <= '0;
    end else begin
      prod   <= 16'(mac_a) * 16'(mac_b);
      prod_v <= mac_en;
      if (prod_v) acc <= acc + 64'(prod);
    end
  end
  assign mac_accum = acc;

  logic [15:0] one_prod   = '0;
  logic        one_prod_v = 1'b0;
  logic [63:0] one_acc    = '0;
  always @(posedge clk) begin
    if (one_mac_clr) begin
      one_prod_v <= 1'b0;
      one_acc    <= '0;
    end else begin
      one_prod   <= 16'(one_mac_a) * 16'(one_mac_b);
      one_prod_v <= one_mac_en;
      if (one_prod_v) one_acc <= one_acc + 64'(one_prod);
    end
  end
  assign one_mac_accum = one_acc;

  // Event recorder, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (mac_clr) begin
      clr_cnt++;
      last_clr_cyc = cyc;
    end
    if (mac_en) begin
      en_cnt++;
      en_log.push_back(cyc);
    end
    if (op_vld && op_rdy) last_hs_cyc = cyc;
    if (res_vld && !prev_res_vld) rvld_rise = cyc;
    prev_res_vld = res_vld;
    if (one_mac_en) one_en_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    op_a   = a;
    op_b   = b;
    op_vld = 1'b1;
    while (!op_rdy && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (op_rdy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL send_timeout: op_rdy=%b required 1 within 20 cycles", op_rdy);
    end
    tick();
  endtask

  task automatic wait_res();
    int n = 0;
    while (!res_vld && n < 30) begin
      tick();
      n++;
    end
    total++;
    if (res_vld !== 1'b1) begin
      bad++;
      $display("[TB] FAIL res_timeout: res_vld=%b required 1 within 30 cycles", res_vld);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    op_vld = 1'b0; op_a = '0; op_b = '0; res_rdy = 1'b0;
    one_op_vld = 1'b0; one_op_a = '0; one_op_b = '0; one_res_rdy = 1'b0;
    #3;
    total++;
    if ({op_rdy, mac_en, mac_clr, res_vld, busy} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b required 00000", {op_rdy, mac_en, mac_clr, res_vld, busy});
    end
    total++;
    if ({mac_a, mac_b} !== 16'h0) begin
      bad++;
      $display("[TB] FAIL reset_operands: got %h required 0000", {mac_a, mac_b});
    end
    total++;
    if (res !== 64'h0) begin
      bad++;
      $display("[TB] FAIL reset_res: got %h required 0", res);
    end
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
    tick();
    total++;
    if ({op_rdy, busy, mac_clr} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL idle_quiet: op_rdy/busy/mac_clr=%b required 000", {op_rdy, busy, mac_clr});
    end
  endtask

  task automatic test_basic();
    int clr0 = clr_cnt;
    int en0  = en_cnt;
    int i0   = en_log.size();
    res_rdy = 1'b1;
    send_pair(8'd1, 8'd2);
    send_pair(8'd3, 8'd4);
    send_pair(8'd5, 8'd6);
    send_pair(8'd7, 8'd8);
    op_vld = 1'b0;
    wait_res();
    tick();
    total++;
    if (res !== 64'h64) begin
      bad++;
      $display("[TB] FAIL basic_res: got %h required 64", res);
    end
    total++;
    if (clr_cnt - clr0 !== 1) begin
      bad++;
      $display("[TB] FAIL basic_clr_count: got %0d required 1", clr_cnt - clr0);
    end
    total++;
    if (en_cnt - en0 !== 4) begin
      bad++;
      $display("[TB] FAIL basic_en_count: got %0d required 4", en_cnt - en0);
    end
    if (en_log.size() - i0 == 4) begin
      total++;
      if (en_log[i0] - last_clr_cyc !== 1) begin
        bad++;
        $display("[TB] FAIL basic_clr_to_en: got %0d cycles required 1", en_log[i0] - last_clr_cyc);
      end
      total++;
      if (en_log[i0+3] - en_log[i0] !== 3) begin
        bad++;
        $display("[TB] FAIL basic_en_consecutive: span %0d required 3", en_log[i0+3] - en_log[i0]);
      end
    end
    total++;
    if (rvld_rise - last_hs_cyc !== MAC_LAT + 2) begin
      bad++;
      $display("[TB] FAIL basic_latency: got %0d required %0d", rvld_rise - last_hs_cyc, MAC_LAT + 2);
    end
    total++;
    if ({res_vld, busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL basic_accept: res_vld/busy=%b required 00", {res_vld, busy});
    end
  endtask

  task automatic test_max_operands();
    res_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send_pair(8'd255, 8'd255);
    op_vld = 1'b0;
    wait_res();
    total++;
    if (res !== 64'h3F804) begin
      bad++;
      $display("[TB] FAIL max_res: got %h required 3f804", res);
    end
    tick();
    for (int i = 0; i < 4; i++) send_pair(8'd0, 8'd0);
    op_vld = 1'b0;
    wait_res();
    total++;
    if (res !== 64'h0) begin
      bad++;
      $display("[TB] FAIL zero_after_max: got %h required 0", res);
    end
    tick();
  endtask

  task automatic test_bubbles();
    logic [6:0] pat = 7'b1011001;
    int en0 = en_cnt;
    int i0  = en_log.size();
    int n   = 0;
    res_rdy = 1'b1;
    op_a = 8'd2;
    op_b = 8'd3;
    op_vld = 1'b1;
    while (!op_rdy && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 7; i++) begin
      op_vld = pat[i];
      tick();
    end
    op_vld = 1'b0;
    wait_res();
    total++;
    if (res !== 64'd24) begin
      bad++;
      $display("[TB] FAIL bubble_res: got %0d required 24", res);
    end
    tick();
    total++;
    if (en_cnt - en0 !== 4) begin
      bad++;
      $display("[TB] FAIL bubble_en_count: got %0d required 4", en_cnt - en0);
    end
    if (en_log.size() - i0 == 4) begin
      total++;
      if ({en_log[i0+1] - en_log[i0], en_log[i0+2] - en_log[i0+1], en_log[i0+3] - en_log[i0+2]}
          !== {32'd3, 32'd1, 32'd2}) begin
        bad++;
        $display("[TB] FAIL bubble_en_gaps: got %0d,%0d,%0d required 3,1,2",
                 en_log[i0+1] - en_log[i0], en_log[i0+2] - en_log[i0+1], en_log[i0+3] - en_log[i0+2]);
      end
    end
  endtask

  task automatic test_backpressure();
    res_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_pair(8'd2, 8'd2);
    op_vld = 1'b0;
    wait_res();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (res !== 64'd16 || {res_vld, op_rdy, busy} !== 3'b101) begin
        bad++;
        $display("[TB] FAIL hold_%0d: res=%0d vld/rdy/busy=%b required 16 and 101",
                 k, res, {res_vld, op_rdy, busy});
      end
      tick();
    end
    res_rdy = 1'b1;
    op_a = 8'd1;
    op_b = 8'd1;
    op_vld = 1'b1;
    tick();
    total++;
    if (res !== 64'd16 || {res_vld, op_rdy, busy} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL release_idle: res=%0d vld/rdy/busy=%b required 16 and 000",
               res, {res_vld, op_rdy, busy});
    end
    tick();
    total++;
    if ({op_rdy, busy} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL gap_clear: rdy/busy=%b required 01", {op_rdy, busy});
    end
    tick();
    total++;
    if (op_rdy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL gap_feed: op_rdy=%b required 1", op_rdy);
    end
    for (int i = 0; i < 4; i++) send_pair(8'd1, 8'd1);
    op_vld = 1'b0;
    wait_res();
    total++;
    if (res !== 64'd4) begin
      bad++;
      $display("[TB] FAIL after_gap_res: got %0d required 4", res);
    end
    tick();
  endtask

  task automatic test_reset_mid_feed();
    res_rdy = 1'b1;
    send_pair(8'd3, 8'd5);
    send_pair(8'd7, 8'd9);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({op_rdy, mac_en, mac_clr, res_vld, busy} !== 5'b0 || {mac_a, mac_b} !== 16'h0 || res !== 64'h0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: ctrl=%b ops=%h res=%h required all 0",
               {op_rdy, mac_en, mac_clr, res_vld, busy}, {mac_a, mac_b}, res);
    end
    op_vld = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
    total++;
    if ({res_vld, busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL midreset_no_result: vld/busy=%b required 00", {res_vld, busy});
    end
    for (int i = 0; i < 4; i++) send_pair(8'd1, 8'd1);
    op_vld = 1'b0;
    wait_res();
    total++;
    if (res !== 64'd4) begin
      bad++;
      $display("[TB] FAIL midreset_new_job: got %0d required 4", res);
    end
    tick();
  endtask

  task automatic test_single_term();
    int n   = 0;
    int en0 = one_en_cnt;
    one_res_rdy = 1'b1;
    one_op_a = 8'd9;
    one_op_b = 8'd9;
    one_op_vld = 1'b1;
    while (!one_op_rdy && n < 20) begin
      tick();
      n++;
    end
    tick();
    one_op_vld = 1'b0;
    n = 0;
    while (!one_res_vld && n < 30) begin
      tick();
      n++;
    end
    total++;
    if (one_res !== 64'd81 || one_res_vld !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_res: res=%0d vld=%b required 81 and 1", one_res, one_res_vld);
    end
    tick();
    total++;
    if (one_en_cnt - en0 !== 1) begin
      bad++;
      $display("[TB] FAIL single_en_count: got %0d required 1", one_en_cnt - en0);
    end
    total++;
    if ({one_res_vld, one_busy} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL single_accept: vld/busy=%b required 00", {one_res_vld, one_busy});
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_basic();
    test_max_operands();
    test_bubbles();
    test_backpressure();
    test_reset_mid_feed();
    test_single_term();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
Initiator side of the gated multiply-accumulate datapath. Accepts a stream of 8-bit operand pairs over a valid/ready handshake and issues N_TERMS of them to the MAC with correct clear/enable timing. Waits out the MAC pipeline latency, then captures the 64-bit accumulator and presents it downstream over a valid/ready handshake. It sits between the operand source and the MAC, and owns every MAC control input.

Parameters:
N_TERMS, 8, operand pairs per dot product (>=1)
MAC_LAT, 2, cycles from a mac_en cycle to its product appearing in mac_accum (product reg + accumulate stage)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
op_vld  input  1  operand pair valid
op_rdy  output  1  sequencer can accept operand pair
op_a  input  8  operand A
op_b  input  8  operand B
mac_a  output  8  registered A to MAC
mac_b  output  8  registered B to MAC
mac_en  output  1  registered MAC enable, one cycle per term
mac_clr  output  1  registered MAC accumulator clear
mac_accum  input  64  MAC accumulator value
res_vld  output  1  result valid
res_rdy  input  1  downstream accepts result
res  output  64  captured dot-product result
busy  output  1  high in any state but IDLE

Behaviour:
- Reset: async, active-high. State=IDLE. op_rdy, mac_a, mac_b, mac_en, mac_clr, res_vld, res, busy and both counters all 0.
- FSM states: IDLE, CLEAR, FEED, DRAIN, PRESENT.
- IDLE: op_rdy=0. op_vld=1 -> CLEAR. The operand is not consumed.
- CLEAR: mac_clr=1 for exactly one cycle; term_cnt<=0 -> FEED.
- FEED: op_rdy=1. A handshake is op_vld&op_rdy in cycle t. On a handshake, mac_a/mac_b<=op_a/op_b and mac_en=1 in cycle t+1. Cycles without a handshake give mac_en=0 next cycle, and mac_a/mac_b hold.
- FEED, term_cnt: increments per handshake. The handshake with term_cnt==N_TERMS-1 is the last: go to DRAIN and load wait_cnt=MAC_LAT. op_rdy is 0 from the next cycle.
- DRAIN: op_rdy=0, mac_en is 0 after its final pulse. wait_cnt decrements each cycle. In the cycle wait_cnt==0 (cycle t+1+MAC_LAT after the last handshake at t), res<=mac_accum and res_vld<=1, then go to PRESENT.
- PRESENT: res and res_vld are held stable until res_rdy=1. The cycle res_vld&res_rdy: res_vld<=0 and go to IDLE. res keeps its last value.
- Back-to-back jobs: minimum gap is IDLE+CLEAR, 2 cycles from result acceptance to the next op_rdy.
- Arithmetic: none local. The result is mac_accum unmodified. Max sum 65025*N_TERMS must fit in 64 bits, which always holds. term_cnt width is $clog2(N_TERMS+1). wait_cnt width is $clog2(MAC_LAT+1).
- N_TERMS=1: FEED is exactly one handshake, then DRAIN.
- Reset mid-operation: all outputs return to reset values at once and no result is emitted. A stale MAC accumulator is harmless because every job starts with CLEAR.
- mac_clr and mac_en are never high in the same cycle.
- All outputs are registered; there is no combinational input-to-output path except op_rdy, which is decoded from state.

Decomposition:
- Package mac_seq_pkg: state enum typedef (IDLE, CLEAR, FEED, DRAIN, PRESENT), operand width 8 and accumulator width 64 as localparams.
- Single module, no sub-module. The bench provides a behavioural MAC model honouring MAC_LAT, or instantiates the gated MAC.

Test Plan:
- Basic: N_TERMS=4, pairs (1,2),(3,4),(5,6),(7,8) back-to-back, res_rdy=1 -> mac_clr one cycle before the first mac_en, 4 consecutive mac_en pulses, res=0x64 with res_vld exactly MAC_LAT+2 cycles after the last handshake.
- Max operands: 4 pairs (255,255) -> res=0x3F804. Second job (0,0)x4 -> res=0, confirming the clear between jobs.
- Bubbles: op_vld toggles 1,0,0,1,1,0,1 with pairs (2,3) -> mac_en gaps match, exactly 4 pulses, res=24.
- Backpressure: res_rdy low 5 cycles after res_vld -> res, res_vld stable, op_rdy=0, busy=1. Release -> IDLE and 2-cycle gap before next op_rdy.
- Reset mid-FEED after 2 handshakes -> all outputs 0 async. A new job (1,1)x4 gives res=4.
- N_TERMS=1 build: pair (9,9) -> single mac_en, res=81.
